mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_arb2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the CPU/debug memory port arbiter:
//   default data/address widths and the access FSM state type.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin selector between the CPU and debug requesters.
//   Ports:
//     i_req_cpu   - CPU request
//     i_req_dbg   - debug request
//     i_last_dbg  - 1 when debug was granted last
//     o_grant_dbg - 1 selects debug, 0 selects CPU (meaningful only when
//                   at least one request is high)
module rr_arb2 (
  input  logic i_req_cpu,
  input  logic i_req_dbg,
  input  logic i_last_dbg,
  output logic o_grant_dbg
);

  always_comb begin
    if (i_req_cpu && i_req_dbg) begin
      // contention: the side that did not win last time goes now
      o_grant_dbg = ~i_last_dbg;
    end else begin
      o_grant_dbg = i_req_dbg;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between a CPU port and a
//   test/debug port. Each access walks IDLE -> ISSUE -> WAIT -> RESP.
//   Ports:
//     clk, reset                  - clock, async active-high reset
//     cpu_req/we/addr/wdata       - CPU request side
//     cpu_ack, cpu_rdata          - CPU completion pulse and read data
//     dbg_*                       - same set for the debug port
//     mem_addr/wdata/we, mem_rdata- memory interface (1-cycle read latency)
//     busy                        - high whenever an access is in flight
//     owner                       - requester of current/last access (1=debug)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter bit DBG_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_last_dbg;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_grant_dbg;

  rr_arb2 u_rr (
    .i_req_cpu   (cpu_req),
    .i_req_dbg   (dbg_req),
    .i_last_dbg  (r_last_dbg),
    .o_grant_dbg (w_grant_dbg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= DBG_FIRST;
      r_last_dbg  <= ~DBG_FIRST;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req || dbg_req) begin
            r_state     <= S_ISSUE;
            r_owner     <= w_grant_dbg;
            r_last_dbg  <= w_grant_dbg;
            r_mem_we    <= w_grant_dbg ? dbg_we    : cpu_we;
            r_mem_addr  <= w_grant_dbg ? dbg_addr  : cpu_addr;
            r_mem_wdata <= w_grant_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        S_ISSUE: begin
          // write strobe lives for the ISSUE cycle only
          r_state  <= S_WAIT;
          r_mem_we <= 1'b0;
        end
        S_WAIT: begin
          r_state <= S_RESP;
          if (r_owner) begin
            r_dbg_rdata <= mem_rdata;
            r_dbg_ack   <= 1'b1;
          end else begin
            r_cpu_rdata <= mem_rdata;
            r_cpu_ack   <= 1'b1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_cpu_ack <= 1'b0;
          r_dbg_ack <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign owner     = r_owner;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter: a synchronous memory model, a
//   transaction-level reference (access age since grant), directed
//   scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_ack, dbg_ack, mem_we, busy, owner;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  int n_checks = 0;
  int n_err    = 0;
  int wecnt    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .DBG_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  // environment memory: single port, synchronous, read-before-write
  logic [15:0] tbmem [0:255];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= '0;
      tbmem[0] <= 16'hAE07;
      mem_rdata <= '0;
    end else begin
      if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= tbmem[mem_addr[7:0]];
    end
  end

  always @(negedge clk) if (mem_we) wecnt <= wecnt + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: one access at a time, described by its age in cycles since
  // the grant (0 = address out, 1 = memory reading, 2 = response).
  logic [15:0] ref_mem [0:255];
  bit          m_active, m_who, m_we, m_last, m_owner;
  int          m_age;
  logic [15:0] m_addr, m_wdata, m_rval;
  logic [15:0] e_cpu_rdata, e_dbg_rdata;
  bit          cpu_known, dbg_known;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) ref_mem[i] <= '0;
        ref_mem[0] <= 16'hAE07;
      end
      m_active    <= 1'b0;
      m_age       <= 0;
      m_owner     <= 1'b1;
      m_last      <= 1'b0;
      e_cpu_rdata <= '0;
      e_dbg_rdata <= '0;
      cpu_known   <= 1'b1;
      dbg_known   <= 1'b1;
    end else if (m_active) begin
      m_age <= m_age + 1;
      if (m_age == 0) begin
        m_rval <= ref_mem[m_addr[7:0]];
        if (m_we) ref_mem[m_addr[7:0]] <= m_wdata;
      end else if (m_age == 1) begin
        if (m_who) begin e_dbg_rdata <= m_rval; dbg_known <= !m_we; end
        else       begin e_cpu_rdata <= m_rval; cpu_known <= !m_we; end
      end else begin
        m_active <= 1'b0;
      end
    end else if (cpu_req || dbg_req) begin
      bit w;
      w = (cpu_req && dbg_req) ? !m_last : dbg_req;
      m_who    <= w;
      m_last   <= w;
      m_owner  <= w;
      m_we     <= w ? dbg_we    : cpu_we;
      m_addr   <= w ? dbg_addr  : cpu_addr;
      m_wdata  <= w ? dbg_wdata : cpu_wdata;
      m_active <= 1'b1;
      m_age    <= 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && !mem_init) begin
      check("busy",    busy,    m_active);
      check("owner",   owner,   m_owner);
      check("cpu_ack", cpu_ack, m_active && m_age == 2 && !m_who);
      check("dbg_ack", dbg_ack, m_active && m_age == 2 && m_who);
      check("mem_we",  mem_we,  m_active && m_age == 0 && m_we);
      if (m_active && m_age < 2) check("mem_addr", mem_addr, m_addr);
      if (m_active && m_age == 0 && m_we) check("mem_wdata", mem_wdata, m_wdata);
      if (cpu_known) check("cpu_rdata", cpu_rdata, e_cpu_rdata);
      if (dbg_known) check("dbg_rdata", dbg_rdata, e_dbg_rdata);
    end
  end

  task automatic access(input bit dbg, input bit we, input logic [15:0] a,
                        input logic [15:0] d, output int lat);
    if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (dbg ? dbg_ack : cpu_ack) begin lat = i; break; end
    end
    cpu_req = 0;
    dbg_req = 0;
    if (lat < 0) check("access_timeout", 0, 1);
  endtask

  initial begin
    int lat, w0, acks, seen;
    int at_q [4];
    bit who_q [4];

    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 1);
    check("rst_acks", {cpu_ack, dbg_ack}, 0);
    check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;

    // debug read of preloaded word
    @(negedge clk);
    access(1, 0, 16'h0000, 16'h0, lat);
    check("r036_latency", lat, 3);
    check("r036_dbg_rdata", dbg_rdata, 16'hAE07);
    check("r036_cpu_ack", cpu_ack, 0);
    @(negedge clk);

    // cpu write then debug readback
    w0 = wecnt;
    access(0, 1, 16'h0005, 16'h1234, lat);
    @(negedge clk);
    check("r037_we_cycles", wecnt - w0, 1);
    access(1, 0, 16'h0005, 16'h0, lat);
    check("r037_dbg_rdata", dbg_rdata, 16'h1234);
    @(negedge clk);

    // one-cycle cpu request still completes
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0005;
    @(negedge clk);
    cpu_req = 0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    check("r039_ack_pulses", acks, 1);
    check("r039_cpu_rdata", cpu_rdata, 16'h1234);

    // reset while a write sits in ISSUE
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0003; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    check("r040_we_issue", mem_we, 1);
    cpu_req = 0;
    #1 reset = 1'b1;
    #1;
    check("r040_we_dropped", mem_we, 0);
    check("r040_busy", busy, 0);
    check("r040_acks", {cpu_ack, dbg_ack}, 0);
    @(negedge clk);
    check("r040_mem3", tbmem[3], 16'h0000);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) acks++;
    end
    check("r040_no_ack", acks, 0);

    // continuous contention from reset alternates, debug first
    reset = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0002;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) begin
        if (seen < 4) begin who_q[seen] = dbg_ack; at_q[seen] = i; end
        seen++;
      end
    end
    cpu_req = 0; dbg_req = 0;
    check("r038_ack_count", seen, 4);
    check("r038_order", {who_q[0], who_q[1], who_q[2], who_q[3]}, 4'b1010);
    check("r038_t0", at_q[0], 3);
    check("r038_t1", at_q[1], 7);
    check("r038_t2", at_q[2], 11);
    check("r038_t3", at_q[3], 15);
    @(negedge clk);

    // randomized traffic with occasional async reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 16'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      dbg_req   = ($urandom_range(0, 2) != 0);
      dbg_we    = $urandom_range(0, 1) == 1;
      dbg_addr  = 16'($urandom_range(0, 15));
      dbg_wdata = 16'($urandom);
    end
    cpu_req = 0; dbg_req = 0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
